// File: rtl/uart_receiver.sv
// UART receive end: 2-flop synchroniser, falling-edge start detect, mid-bit sampling,
// odd-parity and stop-bit checks, one-cycle completion pulse with status.
module uart_receiver #(
  parameter int unsigned CLKS_PER_BIT = 40
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       resend_req,
  output logic       busy
);

  localparam int unsigned CntW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] HalfLast = CntW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shreg_q, shreg_d;
  logic            perr_q, perr_d;
  logic            ferr_q, ferr_d;
  logic            done_q, done_d;

  logic            rx_meta_q, rx_s_q, rx_d_q;
  logic [1:0]      rdy_q;
  logic            armed_q, armed_d;
  logic            fall;

  logic [7:0]      data_q, data_d;
  logic            valid_q, valid_d;
  logic            perr_out_q, perr_out_d;
  logic            ferr_out_q, ferr_out_d;
  logic            rr_q, rr_d;

  // The line must be seen high (with real synchronised data) before a start edge counts,
  // so a line that is low when reset releases cannot start a frame.
  assign armed_d = armed_q | (rdy_q[1] & rx_s_q);
  assign fall    = armed_q & rx_d_q & ~rx_s_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      bit_idx_q  <= '0;
      shreg_q    <= '0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      done_q     <= 1'b0;
      rx_meta_q  <= 1'b1;
      rx_s_q     <= 1'b1;
      rx_d_q     <= 1'b1;
      rdy_q      <= '0;
      armed_q    <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      perr_out_q <= 1'b0;
      ferr_out_q <= 1'b0;
      rr_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_idx_q  <= bit_idx_d;
      shreg_q    <= shreg_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      done_q     <= done_d;
      rx_meta_q  <= rx;
      rx_s_q     <= rx_meta_q;
      rx_d_q     <= rx_s_q;
      rdy_q      <= {rdy_q[0], 1'b1};
      armed_q    <= armed_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      perr_out_q <= perr_out_d;
      ferr_out_q <= ferr_out_d;
      rr_q       <= rr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CntW'(1);
    bit_idx_d = bit_idx_q;
    shreg_d   = shreg_q;
    perr_d    = perr_q;
    ferr_d    = ferr_q;
    done_d    = 1'b0;
    case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (fall) state_d = StStart;
      end
      StStart: begin
        if (cnt_q == HalfLast) begin
          cnt_d = '0;
          if (rx_s_q) begin
            state_d = StIdle;
          end else begin
            state_d   = StData;
            bit_idx_d = '0;
          end
        end
      end
      StData: begin
        if (cnt_q == LastCnt) begin
          cnt_d              = '0;
          shreg_d[bit_idx_q] = rx_s_q;
          if (bit_idx_q == 3'd7) state_d = StParity;
          else                   bit_idx_d = bit_idx_q + 3'd1;
        end
      end
      StParity: begin
        if (cnt_q == LastCnt) begin
          cnt_d   = '0;
          perr_d  = ~(^{shreg_q, rx_s_q});
          state_d = StStop;
        end
      end
      StStop: begin
        // Return to idle mid stop bit so an immediately following start edge is caught.
        if (cnt_q == LastCnt) begin
          cnt_d   = '0;
          ferr_d  = ~rx_s_q;
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    valid_d    = done_q;
    rr_d       = done_q & (perr_q | ferr_q);
    data_d     = data_q;
    perr_out_d = perr_out_q;
    ferr_out_d = ferr_out_q;
    if (done_q) begin
      data_d     = shreg_q;
      perr_out_d = perr_q;
      ferr_out_d = ferr_q;
    end
  end

  assign busy       = (state_q != StIdle);
  assign data_out   = data_q;
  assign valid      = valid_q;
  assign parity_err = perr_out_q;
  assign frame_err  = ferr_out_q;
  assign resend_req = rr_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: drives serial frames and checks captured completions.
module tb_uart_receiver;

  logic       clk;
  logic       reset;
  logic       rx;
  logic [7:0] data_out;
  logic       valid, parity_err, frame_err, resend_req, busy;

  int checks;
  int fails;
  int cyc;
  int fall_cyc;
  int rr_stray;
  int dbl_valid;
  logic prev_valid;

  typedef struct {
    int         c;
    logic [7:0] d;
    logic       pe;
    logic       fe;
    logic       rr;
  } ev_t;
  ev_t evq[$];

  uart_receiver #(.CLKS_PER_BIT(40)) dut (
    .clk        (clk),
    .reset      (reset),
    .rx         (rx),
    .data_out   (data_out),
    .valid      (valid),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .resend_req (resend_req),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc++;

  initial begin
    rr_stray   = 0;
    dbl_valid  = 0;
    prev_valid = 1'b0;
  end

  always @(negedge clk) begin
    if (valid === 1'b1) begin
      ev_t e;
      e.c  = cyc;
      e.d  = data_out;
      e.pe = parity_err;
      e.fe = frame_err;
      e.rr = resend_req;
      evq.push_back(e);
      if (prev_valid === 1'b1) dbl_valid++;
    end
    if (resend_req === 1'b1 && valid !== 1'b1) rr_stray++;
    prev_valid = valid;
  end

  // Called and returns on a negedge; cells alternate c_even/c_odd starting with the start bit.
  task automatic send_frame(input logic [7:0] d, input logic p, input logic s,
                            input int c_even, input int c_odd);
    logic [10:0] f;
    f = {s, p, d, 1'b0};
    for (int i = 0; i < 11; i++) begin
      rx = f[i];
      if (i == 0) fall_cyc = cyc;
      repeat ((i % 2 == 0) ? c_even : c_odd) @(negedge clk);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    rx    = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({data_out, valid, parity_err, frame_err, resend_req, busy} !== 13'h0) begin
      fails++;
      $display("FAIL reset_outputs: got %h expected 0",
               {data_out, valid, parity_err, frame_err, resend_req, busy});
    end
    reset = 1'b0;
    repeat (10) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_idle: busy=%b valid=%b expected 0 0", busy, valid);
    end
  endtask

  task automatic test_good_frame;
    evq.delete();
    send_frame(8'hA5, 1'b1, 1'b1, 40, 40);
    repeat (20) @(negedge clk);
    checks++;
    if (evq.size() != 1) begin
      fails++;
      $display("FAIL good_count: got %0d valids expected 1", evq.size());
    end else begin
      checks++;
      if (evq[0].c - fall_cyc != 424) begin
        fails++;
        $display("FAIL good_latency: got %0d expected 424", evq[0].c - fall_cyc);
      end
      checks++;
      if ({evq[0].d, evq[0].pe, evq[0].fe, evq[0].rr} !== {8'hA5, 3'b000}) begin
        fails++;
        $display("FAIL good_status: got d=%h pe=%b fe=%b rr=%b expected A5 0 0 0",
                 evq[0].d, evq[0].pe, evq[0].fe, evq[0].rr);
      end
    end
    checks++;
    if (data_out !== 8'hA5 || valid !== 1'b0) begin
      fails++;
      $display("FAIL good_hold: data_out=%h valid=%b expected A5 0", data_out, valid);
    end
  endtask

  task automatic test_parity_error;
    evq.delete();
    send_frame(8'h3C, 1'b0, 1'b1, 40, 40);
    repeat (20) @(negedge clk);
    checks++;
    if (evq.size() != 1) begin
      fails++;
      $display("FAIL parity_count: got %0d valids expected 1", evq.size());
    end else begin
      checks++;
      if ({evq[0].d, evq[0].pe, evq[0].fe, evq[0].rr} !== {8'h3C, 3'b101}) begin
        fails++;
        $display("FAIL parity_status: got d=%h pe=%b fe=%b rr=%b expected 3C 1 0 1",
                 evq[0].d, evq[0].pe, evq[0].fe, evq[0].rr);
      end
    end
    repeat (50) @(negedge clk);
    checks++;
    if (parity_err !== 1'b1 || resend_req !== 1'b0) begin
      fails++;
      $display("FAIL parity_hold: parity_err=%b resend_req=%b expected 1 0",
               parity_err, resend_req);
    end
  endtask

  task automatic test_frame_error;
    evq.delete();
    send_frame(8'h81, 1'b1, 1'b0, 40, 40);
    rx = 1'b1;
    repeat (500) @(negedge clk);
    checks++;
    if (evq.size() != 1) begin
      fails++;
      $display("FAIL frame_count: got %0d valids expected 1", evq.size());
    end else begin
      checks++;
      if ({evq[0].d, evq[0].pe, evq[0].fe, evq[0].rr} !== {8'h81, 3'b011}) begin
        fails++;
        $display("FAIL frame_status: got d=%h pe=%b fe=%b rr=%b expected 81 0 1 1",
                 evq[0].d, evq[0].pe, evq[0].fe, evq[0].rr);
      end
    end
    checks++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL frame_no_restart: busy=%b expected 0", busy);
    end
  endtask

  task automatic test_glitch;
    evq.delete();
    rx = 1'b0;
    repeat (10) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL glitch_busy: got %b expected 1", busy);
    end
    rx = 1'b1;
    repeat (40) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || evq.size() != 0) begin
      fails++;
      $display("FAIL glitch_reject: busy=%b valids=%0d expected 0 0", busy, evq.size());
    end
    send_frame(8'h55, 1'b1, 1'b1, 40, 40);
    repeat (20) @(negedge clk);
    checks++;
    if (evq.size() != 1) begin
      fails++;
      $display("FAIL glitch_next_count: got %0d valids expected 1", evq.size());
    end else begin
      checks++;
      if ({evq[0].d, evq[0].pe, evq[0].fe, evq[0].rr} !== {8'h55, 3'b000}) begin
        fails++;
        $display("FAIL glitch_next_status: got d=%h pe=%b fe=%b rr=%b expected 55 0 0 0",
                 evq[0].d, evq[0].pe, evq[0].fe, evq[0].rr);
      end
    end
  endtask

  task automatic test_back_to_back;
    evq.delete();
    send_frame(8'h00, 1'b1, 1'b1, 40, 40);
    send_frame(8'hFF, 1'b1, 1'b1, 40, 40);
    repeat (20) @(negedge clk);
    checks++;
    if (evq.size() != 2) begin
      fails++;
      $display("FAIL b2b_count: got %0d valids expected 2", evq.size());
    end else begin
      checks++;
      if (evq[1].c - evq[0].c != 440) begin
        fails++;
        $display("FAIL b2b_spacing: got %0d expected 440", evq[1].c - evq[0].c);
      end
      checks++;
      if ({evq[0].d, evq[0].pe, evq[0].fe, evq[0].rr,
           evq[1].d, evq[1].pe, evq[1].fe, evq[1].rr} !== {8'h00, 3'b000, 8'hFF, 3'b000}) begin
        fails++;
        $display("FAIL b2b_data: got %h/%b%b%b %h/%b%b%b expected 00/000 FF/000",
                 evq[0].d, evq[0].pe, evq[0].fe, evq[0].rr,
                 evq[1].d, evq[1].pe, evq[1].fe, evq[1].rr);
      end
    end
  endtask

  task automatic test_reset_mid_frame;
    evq.delete();
    // Start bit plus data bits 0..3 of 0x00, then halfway into bit 4.
    rx = 1'b0;
    repeat (40 * 5 + 20) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if ({data_out, valid, parity_err, frame_err, resend_req, busy} !== 13'h0) begin
      fails++;
      $display("FAIL midreset_outputs: got %h expected 0",
               {data_out, valid, parity_err, frame_err, resend_req, busy});
    end
    // Line still low after reset must not start a frame.
    repeat (40) @(negedge clk);
    rx = 1'b1;
    repeat (600) @(negedge clk);
    checks++;
    if (evq.size() != 0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL midreset_abort: valids=%0d busy=%b expected 0 0", evq.size(), busy);
    end
    send_frame(8'hC3, 1'b1, 1'b1, 40, 40);
    repeat (20) @(negedge clk);
    checks++;
    if (evq.size() != 1) begin
      fails++;
      $display("FAIL midreset_next_count: got %0d valids expected 1", evq.size());
    end else begin
      checks++;
      if ({evq[0].d, evq[0].pe, evq[0].fe, evq[0].rr} !== {8'hC3, 3'b000}) begin
        fails++;
        $display("FAIL midreset_next_status: got d=%h pe=%b fe=%b rr=%b expected C3 0 0 0",
                 evq[0].d, evq[0].pe, evq[0].fe, evq[0].rr);
      end
    end
  endtask

  task automatic test_baud_tolerance;
    evq.delete();
    send_frame(8'h96, 1'b1, 1'b1, 38, 42);
    repeat (30) @(negedge clk);
    send_frame(8'h96, 1'b1, 1'b1, 42, 38);
    repeat (30) @(negedge clk);
    checks++;
    if (evq.size() != 2) begin
      fails++;
      $display("FAIL baud_count: got %0d valids expected 2", evq.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        checks++;
        if ({evq[i].d, evq[i].pe, evq[i].fe, evq[i].rr} !== {8'h96, 3'b000}) begin
          fails++;
          $display("FAIL baud_status_%0d: got d=%h pe=%b fe=%b rr=%b expected 96 0 0 0",
                   i, evq[i].d, evq[i].pe, evq[i].fe, evq[i].rr);
        end
      end
    end
  endtask

  task automatic test_pulse_shape;
    checks++;
    if (dbl_valid != 0 || rr_stray != 0) begin
      fails++;
      $display("FAIL pulse_shape: long valids=%0d stray resend=%0d expected 0 0",
               dbl_valid, rr_stray);
    end
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    reset  = 1'b1;
    rx     = 1'b1;
    @(negedge clk);
    test_reset();
    test_good_frame();
    test_parity_error();
    test_frame_error();
    test_glitch();
    test_back_to_back();
    test_reset_mid_frame();
    test_baud_tolerance();
    test_pulse_shape();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
